// File: rtl/sram_port_clr_pkg.sv
// Shared types and helpers for the clearable single-port RAM.
package sram_port_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sram_port_clr_if.sv
// Strobe/acknowledge request port of the clearable RAM, plus clear/busy control.
interface sram_port_clr_if
  import sram_port_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  localparam int LANES = lane_count(DATA_WIDTH);

  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [LANES-1:0]      sel;
  logic                  we;
  logic                  stb;
  logic                  ack;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  clr;
  logic                  busy;

  modport master (output adr, dat_w, sel, we, stb, clr, input ack, dat_r, busy);
  modport slave  (input adr, dat_w, sel, we, stb, clr, output ack, dat_r, busy);
endinterface

// File: rtl/sram_port_clr_array.sv
// Storage core: one byte-wide array per lane, write on the edge, read from a registered address.
module sram_array
  import sram_port_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                             clk,
  input  logic [lane_count(DATA_WIDTH)-1:0] we,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata
);
  localparam int LANES = lane_count(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] addr_reg;

  always_ff @(posedge clk) begin
    if (re) addr_reg <= addr;
  end

  // No reset here so the lanes map onto RAM primitives.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[gi]) mem[addr] <= wdata[8*gi +: 8];
    end

    assign rdata[8*gi +: 8] = mem[addr_reg];
  end
endmodule

// File: rtl/sram_port_clr.sv
// Single-port RAM with strobe/ack handshake, byte enables, optional output register
// and a clear engine that sweeps every location to INIT_VALUE.
module sram_port_clr
  import sram_port_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter bit                    READ_REG   = 1'b0
) (
  input logic         clk,
  input logic         rst,
  sram_port_clr_if.slave bus
);
  localparam int LANES = lane_count(DATA_WIDTH);

  state_t                state_reg;
  logic [ADDR_WIDTH:0]   cnt_reg;
  logic [ADDR_WIDTH:0]   cnt_next;
  logic                  busy_reg;

  logic                  accept;
  logic                  wack_reg;
  logic                  rv1_reg;
  logic                  rv2_reg;
  logic [DATA_WIDTH-1:0] dat_out_reg;
  logic [DATA_WIDTH-1:0] rd_data;

  logic [LANES-1:0]      mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // clr wins over a same-cycle strobe, which is then dropped.
  assign accept   = bus.stb && (state_reg == IDLE) && !bus.clr;
  assign cnt_next = cnt_reg + 1'b1;

  always_comb begin
    mem_we    = '0;
    mem_re    = accept && !bus.we;
    mem_addr  = bus.adr;
    mem_wdata = bus.dat_w;
    if (state_reg == SWEEP) begin
      mem_we    = '1;
      mem_addr  = cnt_reg[ADDR_WIDTH-1:0];
      mem_wdata = INIT_VALUE;
    end else if (accept && bus.we) begin
      mem_we = bus.sel;
    end
  end

  // MSB of the counter flags that the last address has been written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SWEEP;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else if (state_reg == SWEEP) begin
      cnt_reg <= cnt_next;
      if (cnt_next[ADDR_WIDTH]) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end
    end else if (bus.clr) begin
      state_reg <= SWEEP;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wack_reg    <= 1'b0;
      rv1_reg     <= 1'b0;
      rv2_reg     <= 1'b0;
      dat_out_reg <= '0;
    end else begin
      wack_reg <= accept && bus.we;
      rv1_reg  <= accept && !bus.we;
      rv2_reg  <= rv1_reg;
      if (rv1_reg) dat_out_reg <= rd_data;
    end
  end

  sram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(rd_data)
  );

  // With READ_REG a write issued right after a read shares its ack cycle.
  assign bus.ack   = wack_reg | (READ_REG ? rv2_reg : rv1_reg);
  assign bus.dat_r = (!READ_REG && rv1_reg) ? rd_data : dat_out_reg;
  assign bus.busy  = busy_reg;
endmodule
